// File: rtl/spi_cfg_slave.sv
// spi_cfg_slave: SPI mode-0 slave giving a master access to NREG 8-bit configuration registers over 16-bit frames.
// Latency: every action lands 3 sys_clk edges after the pin transition, with +1 cycle of sampling jitter.
// Backpressure: none; the master must keep sys_clk >= 8x sclk and frame each access with cs.
module spi_cfg_slave #(
    parameter int         NREG    = 8,      // 1..128 registers
    parameter logic [7:0] RST_VAL = 8'h00
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       cs,
    input  logic       sclk,
    input  logic       sdin,
    output logic       sdout,
    output logic       wr_pulse,
    output logic [6:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       frame_err
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ADDR    = 2'd1;
    localparam logic [1:0] ST_DATA    = 2'd2;
    localparam logic [1:0] ST_WAIT_CS = 2'd3;

    // Stage [0],[1] form the 2-flop synchronizer; stage [2] is the edge-detect history.
    logic [2:0] cs_sync_q;
    logic [2:0] sclk_sync_q;
    logic [2:0] sdin_sync_q;

    logic       cs_rise;
    logic       cs_fall;
    logic       sclk_rise;
    logic       sclk_fall;
    logic       sdin_smp;

    logic [1:0] state_q,     state_d;
    logic [4:0] bit_cnt_q,   bit_cnt_d;
    logic [7:0] shift_q,     shift_d;
    logic       rw_q,        rw_d;
    logic [6:0] addr_q,      addr_d;
    logic [7:0] rd_buf_q,    rd_buf_d;
    logic       overrun_q,   overrun_d;
    logic       sdout_q,     sdout_d;
    logic       wr_pulse_q,  wr_pulse_d;
    logic       frame_err_q, frame_err_d;
    logic [6:0] wr_addr_q,   wr_addr_d;
    logic [7:0] wr_data_q,   wr_data_d;
    logic [7:0] regs_q [NREG];
    logic [7:0] regs_d [NREG];

    logic [7:0] shift_nxt;
    logic [7:0] rd_val;

    // Synchronize the three asynchronous SPI pins and keep one cycle of history for edges.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            cs_sync_q   <= 3'b000;
            sclk_sync_q <= 3'b000;
            sdin_sync_q <= 3'b000;
        end else begin
            cs_sync_q   <= {cs_sync_q[1:0],   cs};
            sclk_sync_q <= {sclk_sync_q[1:0], sclk};
            sdin_sync_q <= {sdin_sync_q[1:0], sdin};
        end
    end

    // sdin is taken from the history stage so it reflects the line just before sclk rose.
    assign cs_rise   =  cs_sync_q[1]   & ~cs_sync_q[2];
    assign cs_fall   = ~cs_sync_q[1]   &  cs_sync_q[2];
    assign sclk_rise =  sclk_sync_q[1] & ~sclk_sync_q[2];
    assign sclk_fall = ~sclk_sync_q[1] &  sclk_sync_q[2];
    assign sdin_smp  =  sdin_sync_q[2];

    assign shift_nxt = {shift_q[6:0], sdin_smp};

    // Register lookup for the command byte being completed; unimplemented addresses read as zero.
    always_comb begin
        rd_val = 8'h00;
        for (int i = 0; i < NREG; i++) begin
            if (shift_nxt[6:0] == 7'(i)) begin
                rd_val = regs_q[i];
            end
        end
    end

    // Frame FSM: collect command and data bits, stream read data, commit or reject at cs rise.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        rw_d        = rw_q;
        addr_d      = addr_q;
        rd_buf_d    = rd_buf_q;
        overrun_d   = overrun_q;
        sdout_d     = sdout_q;
        wr_pulse_d  = 1'b0;
        frame_err_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        regs_d      = regs_q;

        case (state_q)
            ST_IDLE: begin
                sdout_d = 1'b0;
                // An sclk edge coincident with the cs fall is deliberately not counted.
                if (cs_fall) begin
                    state_d   = ST_ADDR;
                    bit_cnt_d = 5'd0;
                    shift_d   = 8'h00;
                    overrun_d = 1'b0;
                    rd_buf_d  = 8'h00;
                end
            end

            ST_ADDR: begin
                if (cs_rise) begin
                    state_d     = ST_IDLE;
                    sdout_d     = 1'b0;
                    frame_err_d = (bit_cnt_q != 5'd0);
                end else if (sclk_rise) begin
                    shift_d   = shift_nxt;
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == 5'd7) begin
                        state_d  = ST_DATA;
                        rw_d     = shift_nxt[7];
                        addr_d   = shift_nxt[6:0];
                        // Snapshot the read data now so it is ready for the first falling edge.
                        rd_buf_d = shift_nxt[7] ? rd_val : 8'h00;
                    end
                end
            end

            ST_DATA: begin
                if (cs_rise) begin
                    state_d     = ST_IDLE;
                    sdout_d     = 1'b0;
                    frame_err_d = 1'b1;
                end else if (sclk_rise) begin
                    shift_d   = shift_nxt;
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == 5'd15) begin
                        state_d = ST_WAIT_CS;
                    end
                end else if (sclk_fall && rw_q) begin
                    // First fall presents bit7, each later fall presents the next lower bit.
                    sdout_d  = rd_buf_q[7];
                    rd_buf_d = {rd_buf_q[6:0], 1'b0};
                end
            end

            ST_WAIT_CS: begin
                if (cs_rise) begin
                    state_d = ST_IDLE;
                    sdout_d = 1'b0;
                    if (overrun_q) begin
                        frame_err_d = 1'b1;
                    end else if (!rw_q) begin
                        // Out-of-range writes fall through silently.
                        for (int i = 0; i < NREG; i++) begin
                            if (addr_q == 7'(i)) begin
                                regs_d[i]  = shift_q;
                                wr_pulse_d = 1'b1;
                                wr_addr_d  = addr_q;
                                wr_data_d  = shift_q;
                            end
                        end
                    end
                end else if (sclk_rise) begin
                    overrun_d = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                sdout_d = 1'b0;
            end
        endcase
    end

    // State, datapath and register-file flops.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 5'd0;
            shift_q     <= 8'h00;
            rw_q        <= 1'b0;
            addr_q      <= 7'h00;
            rd_buf_q    <= 8'h00;
            overrun_q   <= 1'b0;
            sdout_q     <= 1'b0;
            wr_pulse_q  <= 1'b0;
            frame_err_q <= 1'b0;
            wr_addr_q   <= 7'h00;
            wr_data_q   <= 8'h00;
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= RST_VAL;
            end
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            rw_q        <= rw_d;
            addr_q      <= addr_d;
            rd_buf_q    <= rd_buf_d;
            overrun_q   <= overrun_d;
            sdout_q     <= sdout_d;
            wr_pulse_q  <= wr_pulse_d;
            frame_err_q <= frame_err_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    assign sdout     = sdout_q;
    assign wr_pulse  = wr_pulse_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_cfg_slave.sv
// tb_spi_cfg_slave: drives SPI mode-0 frames into spi_cfg_slave and checks them against a register-array model.
// Latency: checks are taken after a fixed settle gap following each cs rise.
// Backpressure: none; all waits are fixed cycle counts.
module tb_spi_cfg_slave;

    localparam int         NREG    = 8;
    localparam logic [7:0] RST_VAL = 8'h00;
    localparam int         HALF    = 5;   // sys_clk cycles per sclk half period (sclk = sys_clk/10)

    logic       sys_clk = 1'b0;
    logic       rst;
    logic       cs;
    logic       sclk;
    logic       sdin;
    logic       sdout;
    logic       wr_pulse;
    logic [6:0] wr_addr;
    logic [7:0] wr_data;
    logic       frame_err;

    int n_vec = 0;
    int n_bad = 0;

    // Event counters maintained only by the monitor below.
    int wr_cnt = 0;
    int err_cnt = 0;
    int sd_hi_cnt = 0;

    // Reference model: plain register array plus the last committed write.
    logic [7:0] model [NREG];
    logic [6:0] last_addr;
    logic [7:0] last_data;

    spi_cfg_slave #(.NREG(NREG), .RST_VAL(RST_VAL)) dut (
        .sys_clk   (sys_clk),
        .rst       (rst),
        .cs        (cs),
        .sclk      (sclk),
        .sdin      (sdin),
        .sdout     (sdout),
        .wr_pulse  (wr_pulse),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .frame_err (frame_err)
    );

    always #5 sys_clk = ~sys_clk;

    // Count strobes and sdout activity away from the active edge.
    always @(negedge sys_clk) begin
        if (wr_pulse === 1'b1)  wr_cnt++;
        if (frame_err === 1'b1) err_cnt++;
        if (sdout === 1'b1)     sd_hi_cnt++;
    end

    task automatic clk_n(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) model[i] = RST_VAL;
        last_addr = 7'h00;
        last_data = 8'h00;
    endtask

    function automatic logic [7:0] model_read(input logic [6:0] a);
        if (int'(a) < NREG) return model[a[2:0]];
        return 8'h00;
    endfunction

    // One SPI frame: nbits sclk pulses, optional reset pulse during bit rst_bit, then cs high for gap cycles.
    // samp holds the sdout value seen at each of the last 16 sclk rising edges.
    task automatic send_frame(input logic [15:0] word, input int nbits, input int rst_bit,
                              input int gap, output logic [15:0] samp);
        samp = 16'h0000;
        cs   = 1'b0;
        sclk = 1'b0;
        sdin = word[15];
        clk_n(HALF);
        for (int i = 0; i < nbits; i++) begin
            sclk = 1'b1;
            samp = {samp[14:0], sdout};
            if (i == rst_bit) begin
                rst = 1'b1;
                clk_n(3);
                rst = 1'b0;
                clk_n(HALF - 3);
            end else begin
                clk_n(HALF);
            end
            sclk = 1'b0;
            sdin = (i < 15) ? word[14 - i] : 1'b0;
            clk_n(HALF);
        end
        cs   = 1'b1;
        sdin = 1'b0;
        clk_n(gap);
    endtask

    task automatic test_reset();
        int e0;
        rst  = 1'b1;
        cs   = 1'b1;
        sclk = 1'b0;
        sdin = 1'b0;
        clk_n(4);
        n_vec++; if (sdout !== 1'b0)     begin n_bad++; $display("FAIL reset_sdout: got %b want 0", sdout); end
        n_vec++; if (wr_pulse !== 1'b0)  begin n_bad++; $display("FAIL reset_wr_pulse: got %b want 0", wr_pulse); end
        n_vec++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
        n_vec++; if (wr_addr !== 7'h00)  begin n_bad++; $display("FAIL reset_wr_addr: got %h want 00", wr_addr); end
        n_vec++; if (wr_data !== 8'h00)  begin n_bad++; $display("FAIL reset_wr_data: got %h want 00", wr_data); end
        e0  = err_cnt;
        rst = 1'b0;
        model_reset();
        clk_n(8);
        n_vec++; if (err_cnt != e0) begin n_bad++; $display("FAIL reset_release_err: got %0d strobes want 0", err_cnt - e0); end
    endtask

    task automatic test_read_after_reset();
        logic [15:0] s;
        int w0, e0;
        w0 = wr_cnt; e0 = err_cnt;
        send_frame(16'h8500, 16, -1, 10, s);
        n_vec++; if (s[7:0] !== model_read(7'h05)) begin n_bad++; $display("FAIL rd_rstval: got %h want %h", s[7:0], model_read(7'h05)); end
        send_frame(16'hFF00, 16, -1, 10, s);
        n_vec++; if (s[7:0] !== 8'h00) begin n_bad++; $display("FAIL rd_out_of_range: got %h want 00", s[7:0]); end
        n_vec++; if (wr_cnt != w0 || err_cnt != e0) begin n_bad++; $display("FAIL rd_no_strobes: got wr=%0d err=%0d want 0 0", wr_cnt - w0, err_cnt - e0); end
    endtask

    task automatic test_write_read();
        logic [15:0] s;
        int w0, e0, h0;
        w0 = wr_cnt; e0 = err_cnt; h0 = sd_hi_cnt;
        send_frame(16'h0355, 16, -1, 10, s);
        model[3] = 8'h55; last_addr = 7'h03; last_data = 8'h55;
        n_vec++; if (wr_cnt - w0 != 1) begin n_bad++; $display("FAIL wr_pulse_count: got %0d want 1", wr_cnt - w0); end
        n_vec++; if (wr_addr !== last_addr) begin n_bad++; $display("FAIL wr_addr: got %h want %h", wr_addr, last_addr); end
        n_vec++; if (wr_data !== last_data) begin n_bad++; $display("FAIL wr_data: got %h want %h", wr_data, last_data); end
        n_vec++; if (sd_hi_cnt != h0) begin n_bad++; $display("FAIL wr_sdout_quiet: got %0d high cycles want 0", sd_hi_cnt - h0); end
        w0 = wr_cnt;
        send_frame(16'h8300, 16, -1, 10, s);
        n_vec++; if (s[7:0] !== model_read(7'h03)) begin n_bad++; $display("FAIL rd_back: got %h want %h", s[7:0], model_read(7'h03)); end
        n_vec++; if (s[15:8] !== 8'h00) begin n_bad++; $display("FAIL rd_addr_phase_sdout: got %h want 00", s[15:8]); end
        n_vec++; if (wr_cnt != w0 || err_cnt != e0) begin n_bad++; $display("FAIL rd_back_strobes: got wr=%0d err=%0d want 0 0", wr_cnt - w0, err_cnt - e0); end
        n_vec++; if (sdout !== 1'b0) begin n_bad++; $display("FAIL sdout_idle_after_read: got %b want 0", sdout); end
    endtask

    task automatic test_abort();
        logic [15:0] s;
        int w0, e0;
        w0 = wr_cnt; e0 = err_cnt;
        send_frame(16'h02AA, 10, -1, 10, s);
        n_vec++; if (err_cnt - e0 != 1) begin n_bad++; $display("FAIL abort_frame_err: got %0d want 1", err_cnt - e0); end
        n_vec++; if (wr_cnt != w0) begin n_bad++; $display("FAIL abort_no_write: got %0d want 0", wr_cnt - w0); end
        send_frame(16'h8200, 16, -1, 10, s);
        n_vec++; if (s[7:0] !== 8'h00) begin n_bad++; $display("FAIL abort_reg2: got %h want 00", s[7:0]); end
        // cs pulsed low with no sclk at all is a silent no-op.
        e0 = err_cnt;
        send_frame(16'h0000, 0, -1, 10, s);
        n_vec++; if (err_cnt != e0) begin n_bad++; $display("FAIL empty_frame_err: got %0d want 0", err_cnt - e0); end
    endtask

    task automatic test_overrun();
        logic [15:0] s;
        int w0, e0;
        w0 = wr_cnt; e0 = err_cnt;
        send_frame(16'h0111, 17, -1, 10, s);
        n_vec++; if (err_cnt - e0 != 1) begin n_bad++; $display("FAIL overrun_frame_err: got %0d want 1", err_cnt - e0); end
        n_vec++; if (wr_cnt != w0) begin n_bad++; $display("FAIL overrun_no_write: got %0d want 0", wr_cnt - w0); end
        send_frame(16'h8100, 16, -1, 10, s);
        n_vec++; if (s[7:0] !== model_read(7'h01)) begin n_bad++; $display("FAIL overrun_reg1: got %h want %h", s[7:0], model_read(7'h01)); end
    endtask

    task automatic test_oob_write();
        logic [15:0] s;
        int w0, e0;
        w0 = wr_cnt; e0 = err_cnt;
        send_frame({1'b0, 7'h7F, 8'hC3}, 16, -1, 10, s);
        send_frame({1'b0, 7'(NREG), 8'h3C}, 16, -1, 10, s);
        n_vec++; if (wr_cnt != w0 || err_cnt != e0) begin n_bad++; $display("FAIL oob_write_strobes: got wr=%0d err=%0d want 0 0", wr_cnt - w0, err_cnt - e0); end
        n_vec++; if (wr_addr !== last_addr || wr_data !== last_data) begin n_bad++; $display("FAIL oob_write_held: got %h/%h want %h/%h", wr_addr, wr_data, last_addr, last_data); end
    endtask

    task automatic test_rst_mid_frame();
        logic [15:0] s;
        int w0, e0;
        w0 = wr_cnt; e0 = err_cnt;
        send_frame(16'h0466, 16, 12, 10, s);
        model_reset();
        n_vec++; if (wr_cnt != w0 || err_cnt != e0) begin n_bad++; $display("FAIL rst_mid_strobes: got wr=%0d err=%0d want 0 0", wr_cnt - w0, err_cnt - e0); end
        send_frame(16'h0477, 16, -1, 10, s);
        model[4] = 8'h77; last_addr = 7'h04; last_data = 8'h77;
        n_vec++; if (wr_cnt - w0 != 1) begin n_bad++; $display("FAIL rst_mid_one_write: got %0d want 1", wr_cnt - w0); end
        send_frame(16'h8400, 16, -1, 10, s);
        n_vec++; if (s[7:0] !== model_read(7'h04)) begin n_bad++; $display("FAIL rst_mid_reg4: got %h want %h", s[7:0], model_read(7'h04)); end
        send_frame(16'h8300, 16, -1, 10, s);
        n_vec++; if (s[7:0] !== model_read(7'h03)) begin n_bad++; $display("FAIL rst_mid_reg3_cleared: got %h want %h", s[7:0], model_read(7'h03)); end
    endtask

    // Random reads and writes, including out-of-range addresses, with a configurable inter-frame gap.
    task automatic test_random(input int nframes, input int gap);
        logic [15:0] s;
        logic [6:0]  a;
        logic [7:0]  d;
        logic        rd;
        int          w0, e0, h0;
        for (int k = 0; k < nframes; k++) begin
            rd = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) a = 7'($urandom_range(NREG, 127));
            else                           a = 7'($urandom_range(0, NREG - 1));
            d  = 8'($urandom);
            w0 = wr_cnt; e0 = err_cnt; h0 = sd_hi_cnt;
            send_frame({rd, a, rd ? 8'h00 : d}, 16, -1, gap, s);
            if (rd) begin
                n_vec++; if (s[7:0] !== model_read(a)) begin n_bad++; $display("FAIL rand_read a=%h: got %h want %h", a, s[7:0], model_read(a)); end
                n_vec++; if (wr_cnt != w0) begin n_bad++; $display("FAIL rand_read_no_write a=%h: got %0d want 0", a, wr_cnt - w0); end
            end else begin
                if (int'(a) < NREG) begin
                    model[a[2:0]] = d; last_addr = a; last_data = d;
                    n_vec++; if (wr_cnt - w0 != 1) begin n_bad++; $display("FAIL rand_write_pulse a=%h: got %0d want 1", a, wr_cnt - w0); end
                end else begin
                    n_vec++; if (wr_cnt != w0) begin n_bad++; $display("FAIL rand_oob_write a=%h: got %0d want 0", a, wr_cnt - w0); end
                end
                n_vec++; if (wr_addr !== last_addr || wr_data !== last_data) begin n_bad++; $display("FAIL rand_wr_fields: got %h/%h want %h/%h", wr_addr, wr_data, last_addr, last_data); end
                n_vec++; if (sd_hi_cnt != h0) begin n_bad++; $display("FAIL rand_write_sdout: got %0d high cycles want 0", sd_hi_cnt - h0); end
            end
            n_vec++; if (err_cnt != e0) begin n_bad++; $display("FAIL rand_frame_err: got %0d want 0", err_cnt - e0); end
        end
    endtask

    task automatic test_back_to_back();
        test_random(24, 4);
    endtask

    initial begin
        rst  = 1'b1;
        cs   = 1'b1;
        sclk = 1'b0;
        sdin = 1'b0;
        model_reset();
        test_reset();
        test_read_after_reset();
        test_write_read();
        test_abort();
        test_overrun();
        test_oob_write();
        test_rst_mid_frame();
        test_random(40, 10);
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/spi_cfg_slave.md
SPI_CFG_SLAVE -- requirements
Module: spi_cfg_slave

Interface
REQ-001 Parameter NREG, default 8: number of implemented 8-bit configuration registers (addresses 0..NREG-1).
REQ-002 Parameter RST_VAL, default 8'h00: reset value of every register.
REQ-003 sys_clk  in  1  single system clock; all logic on its rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 cs  in  1  SPI chip select from the master, active-low, asynchronous to sys_clk.
REQ-006 sclk  in  1  SPI clock from the master, idle low, asynchronous to sys_clk.
REQ-007 sdin  in  1  serial data from the master; this block samples it.
REQ-008 sdout  out  1  serial data to the master; this block drives it.
REQ-009 wr_pulse  out  1  one-cycle strobe on each committed register write.
REQ-010 wr_addr  out  7  address of the last committed write.
REQ-011 wr_data  out  8  data of the last committed write.
REQ-012 frame_err  out  1  one-cycle strobe when a frame is malformed.

Function
REQ-013 The block SHALL pass cs, sclk and sdin through 2-flop synchronizers, then through one more flop per signal for edge detection; every action below SHALL take effect 3 sys_clk edges after the raw pin transition, with +1 cycle of sampling uncertainty.
REQ-014 The block SHALL require sys_clk >= 8x sclk; slower ratios are unsupported.
REQ-015 The protocol SHALL be SPI mode 0, MSB first, 16-bit frames: bit15 R/W (1=read, 0=write), bits14:8 address, bits7:0 data.
REQ-016 The FSM SHALL have four states: IDLE, ADDR, DATA, WAIT_CS.
REQ-017 IDLE -> ADDR on synchronized cs falling edge; bit counter cleared to 0 and shift register cleared.
REQ-018 In ADDR and DATA, each synchronized sclk rising edge SHALL shift the synchronized sdin into the shift register LSB and increment the 5-bit bit counter.
REQ-019 ADDR -> DATA when the counter reaches 8; R/W and address SHALL be latched at that edge.
REQ-020 On a read frame, the block SHALL load sdout with bit7 of the addressed register on the first synchronized sclk falling edge after the counter reaches 8; subsequent falling edges SHALL shift out bits 6..0.
REQ-021 Reads from address >= NREG SHALL return 8'h00.
REQ-022 DATA -> WAIT_CS when the counter reaches 16.
REQ-023 sdout SHALL be 0 in IDLE, in ADDR, and during write frames.
REQ-024 On synchronized cs rising edge in WAIT_CS after a write frame with address < NREG, the block SHALL update the register, set wr_addr and wr_data, and assert wr_pulse for exactly one cycle.
REQ-025 Write frames to address >= NREG SHALL neither modify state nor assert wr_pulse; frame_err SHALL stay 0.
REQ-026 A cs rising edge in ADDR or DATA (counter 1..15) SHALL abort the frame: no write, frame_err pulses once, FSM returns to IDLE.
REQ-027 A cs rising edge with counter 0 SHALL return to IDLE silently.
REQ-028 Any sclk rising edge in WAIT_CS SHALL set a sticky overrun flag; at cs rise the frame SHALL be discarded and frame_err SHALL pulse once.
REQ-029 A cs rising edge SHALL always return the FSM to IDLE and force sdout to 0 on that same cycle.
REQ-030 sclk edges seen while in IDLE SHALL be ignored.
REQ-031 If cs falling and sclk rising are synchronized in the same cycle, the FSM SHALL enter ADDR only; that sclk edge SHALL not be counted.

Reset
REQ-032 While rst is high, the FSM SHALL be in IDLE, every register SHALL hold RST_VAL, and the counter, shift register and synchronizer flops SHALL be 0.
REQ-033 While rst is high, sdout, wr_pulse and frame_err SHALL be 0, wr_addr SHALL be 7'h00 and wr_data SHALL be 8'h00.
REQ-034 Asserting rst mid-frame SHALL discard the frame; after release, the block SHALL wait for a fresh cs falling edge.

Verification
REQ-035 Write 0x0355 (addr 3, data 0x55), sclk = sys_clk/10 -> one wr_pulse after cs rise with wr_addr=3 and wr_data=0x55; sdout stays 0 throughout.
REQ-036 After REQ-035, read 0x8300 -> sdout bits 8..15 sampled on sclk rising edges equal 0x55; no wr_pulse.
REQ-037 Read 0x8500 after reset -> sdout returns 0x00 (RST_VAL); read 0xFF00 -> 0x00 (out of range).
REQ-038 Write frame 0x02AA with cs raised after 10 bits -> frame_err pulses once; a following read of addr 2 returns 0x00.
REQ-039 Send 17 sclk pulses in one write frame 0x0111 -> frame_err pulses once; reg 1 unchanged; no wr_pulse.
REQ-040 Assert rst during bit 12 of write 0x0466, then send a full write 0x0477 -> reg 4 = 0x77; exactly one wr_pulse.
